// File: rtl/loba_mac_accum_if.sv
// Valid/ready bundle between a LOBA multiplier, the MAC accumulator and its result consumer.
interface loba_mac_accum_if #(
    parameter int PW  = 22,
    parameter int LEN = 16,
    parameter int AW  = 26,
    parameter int CW  = $clog2(LEN + 1)
);
    logic [PW-1:0] in_prod;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_ovf;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output in_prod, in_valid, in_last, out_ready,
        input  in_ready, out_sum, out_count, out_ovf, out_valid
    );

    modport slave (
        input  in_prod, in_valid, in_last, out_ready,
        output in_ready, out_sum, out_count, out_ovf, out_valid
    );
endinterface

// File: rtl/loba_mac_accum.sv
// Signed frame accumulator for LOBA products: sums up to LEN terms, returns sum/count/overflow.
module loba_mac_accum #(
    parameter int PW  = 22,
    parameter int LEN = 16,
    parameter int AW  = 26,
    parameter int CW  = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    loba_mac_accum_if.slave  bus
);
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t               state, state_nxt;
    logic signed [PW-1:0] prod_s;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] acc, sum_add, sum_q;
    logic [CW-1:0]        cnt, cnt_add, count_q;
    logic                 ovf, ovf_add, ovf_q;
    logic                 accept, close;

    function automatic logic add_overflow(input logic signed [AW-1:0] a,
                                          input logic signed [AW-1:0] b,
                                          input logic signed [AW-1:0] s);
        return (a[AW-1] == b[AW-1]) && (s[AW-1] != a[AW-1]);
    endfunction

    assign prod_s   = bus.in_prod;
    assign prod_ext = AW'(prod_s);
    assign sum_add  = acc + prod_ext;
    assign cnt_add  = cnt + CW'(1);
    assign ovf_add  = ovf | add_overflow(acc, prod_ext, sum_add);

    assign bus.in_ready = (state == ACCUM);
    assign accept       = bus.in_valid && bus.in_ready && !clr;
    // in_last on the LEN-th term still closes only once: both conditions share one close
    assign close        = accept && (bus.in_last || cnt == CW'(LEN - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (close)         state_nxt = HOLD;
            HOLD:  if (bus.out_ready) state_nxt = ACCUM;
        endcase
        if (clr) state_nxt = ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    // accumulate stage; result registers load with the post-add values of the closing term
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            acc <= sum_add;
            cnt <= cnt_add;
            ovf <= ovf_add;
            if (close) begin
                sum_q   <= sum_add;
                count_q <= cnt_add;
                ovf_q   <= ovf_add;
            end
        end else if (state == HOLD && bus.out_ready) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end

    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_loba_mac_accum.sv
// Directed scoreboard bench: a 22/16/26 instance (sel=0) and an 8/4/8 instance (sel=1).
module tb_loba_mac_accum;
    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [31:0] prod;
    logic        valid;
    logic        last;
    logic        out_ready;
    logic        sel;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        sel;
        logic [31:0] sum;
        logic [31:0] count;
        logic [31:0] ovf;
    } exp_t;
    exp_t sb[$];

    loba_mac_accum_if #(.PW(22), .LEN(16), .AW(26)) a_if ();
    loba_mac_accum_if #(.PW(8),  .LEN(4),  .AW(8))  b_if ();

    assign a_if.in_prod   = prod[21:0];
    assign a_if.in_valid  = valid && !sel;
    assign a_if.in_last   = last;
    assign a_if.out_ready = out_ready;
    assign b_if.in_prod   = prod[7:0];
    assign b_if.in_valid  = valid && sel;
    assign b_if.in_last   = last;
    assign b_if.out_ready = out_ready;

    loba_mac_accum #(.PW(22), .LEN(16), .AW(26)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(a_if.slave));
    loba_mac_accum #(.PW(8), .LEN(4), .AW(8)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(b_if.slave));

    logic [31:0] o_sum, o_count, o_ovf, o_valid, o_ready;
    assign o_sum   = sel ? 32'(b_if.out_sum)   : 32'(a_if.out_sum);
    assign o_count = sel ? 32'(b_if.out_count) : 32'(a_if.out_count);
    assign o_ovf   = sel ? 32'(b_if.out_ovf)   : 32'(a_if.out_ovf);
    assign o_valid = sel ? 32'(b_if.out_valid) : 32'(a_if.out_valid);
    assign o_ready = sel ? 32'(b_if.in_ready)  : 32'(a_if.in_ready);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int sum, input int count, input int ovf);
        exp_t e;
        e.sel   = sel;
        e.sum   = sel ? (32'(sum) & 32'hFF) : (32'(sum) & 32'h3FF_FFFF);
        e.count = 32'(count);
        e.ovf   = 32'(ovf);
        sb.push_back(e);
    endtask

    task automatic send(input int v, input logic l);
        prod  = 32'(v);
        valid = 1'b1;
        last  = l;
        @(posedge clk);
        #1;
        valid = 1'b0;
        last  = 1'b0;
        prod  = '0;
    endtask

    task automatic expect_result(input string tag);
        logic seen;
        exp_t e;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_valid == 32'd1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_valid"}, 32'(seen), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"},   o_sum,   e.sum);
            check({tag, "_count"}, o_count, e.count);
            check({tag, "_ovf"},   o_ovf,   e.ovf);
            check({tag, "_in_ready_hold"}, o_ready, 32'd0);
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, o_valid, 32'd0);
        check({tag, "_hs_ready"}, o_ready, 32'd1);
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; prod = '0; valid = 1'b0; last = 1'b0;
        out_ready = 1'b0; sel = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", o_valid, 32'd0);
        check("rst_sum",   o_sum,   32'd0);
        check("rst_count", o_count, 32'd0);
        check("rst_ovf",   o_ovf,   32'd0);
        check("rst_ready", o_ready, 32'd1);

        // asynchronous reset mid-frame, then a full frame of ones
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", o_valid, 32'd0);
        check("async_rst_count", o_count, 32'd0);
        check("async_rst_ready", o_ready, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 15; i++) send(1, 1'b0);
        push_exp(16, 16, 0);
        send(1, 1'b0);
        expect_result("ones16");
        handshake("ones16");

        // full frame on the LEN=4 instance
        sel = 1'b1;
        send(100, 1'b0); send(-30, 1'b0); send(7, 1'b0);
        push_exp(78, 4, 0);
        send(1, 1'b0);
        expect_result("full4");
        handshake("full4");

        // early close with a negative sum, then backpressure
        sel = 1'b0;
        send(5, 1'b0);
        push_exp(-4, 2, 0);
        send(-9, 1'b1);
        expect_result("early");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_sum",   o_sum,   32'h3FF_FFFC);
            check("bp_count", o_count, 32'd2);
            check("bp_ready", o_ready, 32'd0);
        end
        handshake("early");
        push_exp(7, 1, 0);
        send(7, 1'b1);
        expect_result("after_bp");
        handshake("after_bp");

        // in_last without in_valid is ignored
        last = 1'b1;
        @(posedge clk);
        #1 last = 1'b0;
        check("last_novalid", o_valid, 32'd0);
        send(9, 1'b0);
        push_exp(10, 2, 0);
        send(1, 1'b1);
        expect_result("last_ign");
        handshake("last_ign");

        // signed overflow on the 8-bit accumulator, then a clean frame
        sel = 1'b1;
        send(100, 1'b0); send(100, 1'b0); send(0, 1'b0);
        push_exp(-56, 4, 1);
        send(0, 1'b0);
        expect_result("ovf");
        handshake("ovf");
        send(1, 1'b0); send(1, 1'b0); send(1, 1'b0);
        push_exp(4, 4, 0);
        send(1, 1'b0);
        expect_result("ovf_clear");
        handshake("ovf_clear");

        // abort mid-frame drops the term presented with clr
        send(3, 1'b0); send(3, 1'b0); send(3, 1'b0);
        clr = 1'b1; valid = 1'b1; prod = 32'd50;
        @(posedge clk);
        #1 clr = 1'b0; valid = 1'b0; prod = '0;
        check("clr_valid", o_valid, 32'd0);
        check("clr_ready", o_ready, 32'd1);
        send(2, 1'b0); send(2, 1'b0); send(2, 1'b0);
        push_exp(8, 4, 0);
        send(2, 1'b0);
        expect_result("abort");
        clr = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0; out_ready = 1'b0;
        check("clr_hold_valid", o_valid, 32'd0);
        check("clr_hold_ready", o_ready, 32'd1);
        push_exp(1, 1, 0);
        send(1, 1'b1);
        expect_result("post_clr");
        handshake("post_clr");

        // in_last on the LEN-th term closes exactly once
        send(1, 1'b0); send(1, 1'b0); send(1, 1'b0);
        push_exp(4, 4, 0);
        send(1, 1'b1);
        expect_result("last_at_len");
        handshake("last_at_len");
        repeat (2) begin
            @(negedge clk);
            check("no_double_close", o_valid, 32'd0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
